datapath_unit: RTL and testbench

DATAPATH_UNIT -- requirements
Module: datapath_unit

---
 rtl/datapath_unit.sv | 174 +++++++++++++++++
 tb/tb_datapath_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_unit.sv
// Accumulator datapath with a small register file, driven by a 3-state command FSM.
// Define DATAPATH_UNIT_MUL_EN to build the multiplier for ALU function 110 (otherwise PASS).
module datapath_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 8,
  localparam int unsigned RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  input  logic [2:0]        opr,
  input  logic [RSEL_W-1:0] rsel,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] ext_data,
  output logic [DATA_W-1:0] ac_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              z,
  output logic              c,
  output logic              done
);

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpWtr = 3'b001;
  localparam logic [2:0] OpInc = 3'b010;
  localparam logic [2:0] OpClr = 3'b011;
  localparam logic [2:0] OpLda = 3'b100;
  localparam logic [2:0] OpAlu = 3'b101;
  localparam logic [2:0] OpSta = 3'b110;
  localparam logic [2:0] OpRsv = 3'b111;

  localparam logic [2:0] AluPass = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;
  localparam logic [2:0] AluAnd  = 3'b011;
  localparam logic [2:0] AluOr   = 3'b100;
  localparam logic [2:0] AluXor  = 3'b101;
  localparam logic [2:0] AluMul  = 3'b110;
  localparam logic [2:0] AluInc  = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   ac_q;
  logic [DATA_W-1:0]   bus_q;
  logic                z_q;
  logic                c_q;
  logic                done_q;
  logic [2:0]          opr_q;
  logic [RSEL_W-1:0]   rsel_q;
  logic [2:0]          alu_op_q;
  logic [DATA_W-1:0]   ext_q;

  logic [DATA_W-1:0]   bus_val;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
`ifdef DATAPATH_UNIT_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  always_comb begin
    bus_val = '0;
    case (opr_q)
      OpWtr:        bus_val = ext_q;
      OpNop, OpRsv: bus_val = '0;
      default:      bus_val = regs_q[rsel_q];
    endcase
  end

  // Sum/difference carry one extra bit so its MSB is the carry or the borrow.
  always_comb begin
    sum     = '0;
    alu_res = bus_val;
    alu_c   = 1'b0;
`ifdef DATAPATH_UNIT_MUL_EN
    prod    = '0;
`endif
    case (alu_op_q)
      AluPass: alu_res = bus_val;
      AluAdd: begin
        sum     = {1'b0, ac_q} + {1'b0, bus_val};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      AluSub: begin
        sum     = {1'b0, ac_q} - {1'b0, bus_val};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      AluAnd: alu_res = ac_q & bus_val;
      AluOr:  alu_res = ac_q | bus_val;
      AluXor: alu_res = ac_q ^ bus_val;
      AluMul: begin
`ifdef DATAPATH_UNIT_MUL_EN
        prod    = {{DATA_W{1'b0}}, ac_q} * {{DATA_W{1'b0}}, bus_val};
        alu_res = prod[DATA_W-1:0];
        alu_c   = |prod[2*DATA_W-1:DATA_W];
`else
        alu_res = bus_val;
        alu_c   = 1'b0;
`endif
      end
      AluInc: begin
        sum     = {1'b0, ac_q} + (DATA_W + 1)'(1);
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      default: alu_res = bus_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      ac_q     <= '0;
      bus_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
      opr_q    <= OpNop;
      rsel_q   <= '0;
      alu_op_q <= AluPass;
      ext_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ctrl_valid) begin
            opr_q    <= opr;
            rsel_q   <= rsel;
            alu_op_q <= alu_op;
            ext_q    <= ext_data;
            state_q  <= StExec;
          end
        end
        StExec: begin
          bus_q <= bus_val;
          case (opr_q)
            OpWtr: regs_q[rsel_q] <= ext_q;
            OpInc: regs_q[rsel_q] <= regs_q[rsel_q] + DATA_W'(1);
            OpClr: regs_q[rsel_q] <= '0;
            OpLda: begin
              ac_q <= bus_val;
              z_q  <= (bus_val == '0);
              c_q  <= 1'b0;
            end
            OpAlu: begin
              ac_q <= alu_res;
              z_q  <= (alu_res == '0);
              c_q  <= alu_c;
            end
            OpSta:   regs_q[rsel_q] <= ac_q;
            default: ;
          endcase
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl_ready = (state_q == StIdle);
  assign ac_out     = ac_q;
  assign bus_out    = bus_q;
  assign z          = z_q;
  assign c          = c_q;
  assign done       = done_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit (DATA_W=8, NREGS=8); honours DATAPATH_UNIT_MUL_EN.
module tb_datapath_unit;

  logic       clk;
  logic       rst;
  logic       ctrl_valid;
  logic       ctrl_ready;
  logic [2:0] opr;
  logic [2:0] rsel;
  logic [2:0] alu_op;
  logic [7:0] ext_data;
  logic [7:0] ac_out;
  logic [7:0] bus_out;
  logic       z;
  logic       c;
  logic       done;

  int errors = 0;
  int checks = 0;

  datapath_unit #(.DATA_W(8), .NREGS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .opr        (opr),
    .rsel       (rsel),
    .alu_op     (alu_op),
    .ext_data   (ext_data),
    .ac_out     (ac_out),
    .bus_out    (bus_out),
    .z          (z),
    .c          (c),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and follow it through EXEC and DONE back to IDLE.
  task automatic cmd(input logic [2:0] o, input logic [2:0] r, input logic [2:0] a,
                     input logic [7:0] d);
    ctrl_valid = 1'b1;
    opr = o; rsel = r; alu_op = a; ext_data = d;
    tick();
    // Scramble inputs after the accepting edge; they must be ignored.
    ctrl_valid = 1'b0;
    opr = ~o; rsel = ~r; alu_op = ~a; ext_data = ~d;
    chk("exec_ready", ctrl_ready, 0);
    chk("exec_done", done, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("done_ready", ctrl_ready, 0);
    tick();
    chk("idle_done", done, 0);
    chk("idle_ready", ctrl_ready, 1);
  endtask

  initial begin
    rst = 1'b1; ctrl_valid = 1'b0; opr = 3'd0; rsel = 3'd0; alu_op = 3'd0; ext_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ac", ac_out, 8'h00);
    chk("rst_bus", bus_out, 8'h00);
    chk("rst_z", z, 0);
    chk("rst_c", c, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ctrl_ready, 1);

    // WTR r3 <= 5A, LDA r3
    cmd(3'b001, 3'd3, 3'd0, 8'h5A);
    chk("wtr_bus", bus_out, 8'h5A);
    chk("wtr_ac", ac_out, 8'h00);
    cmd(3'b100, 3'd3, 3'd0, 8'h00);
    chk("lda_ac", ac_out, 8'h5A);
    chk("lda_bus", bus_out, 8'h5A);
    chk("lda_z", z, 0);
    chk("lda_c", c, 0);

    // AC=FF; ADD r1(01) -> 00 z c; SUB r1 -> FF borrow
    cmd(3'b001, 3'd0, 3'd0, 8'hFF);
    cmd(3'b100, 3'd0, 3'd0, 8'h00);
    chk("ldff_ac", ac_out, 8'hFF);
    cmd(3'b001, 3'd1, 3'd0, 8'h01);
    cmd(3'b101, 3'd1, 3'b001, 8'h00);
    chk("add_ac", ac_out, 8'h00);
    chk("add_z", z, 1);
    chk("add_c", c, 1);
    chk("add_bus", bus_out, 8'h01);
    cmd(3'b101, 3'd1, 3'b010, 8'h00);
    chk("sub_ac", ac_out, 8'hFF);
    chk("sub_c", c, 1);
    chk("sub_z", z, 0);

    // INC wraps; flags held by non-ALU/LDA opcodes
    cmd(3'b001, 3'd7, 3'd0, 8'hFF);
    cmd(3'b010, 3'd7, 3'd0, 8'h00);
    chk("inc_bus", bus_out, 8'hFF);
    chk("inc_c_hold", c, 1);
    chk("inc_ac_hold", ac_out, 8'hFF);
    cmd(3'b100, 3'd7, 3'd0, 8'h00);
    chk("inc_wrap_ac", ac_out, 8'h00);
    chk("inc_wrap_z", z, 1);
    chk("inc_wrap_c", c, 0);
    cmd(3'b001, 3'd2, 3'd0, 8'h44);
    cmd(3'b100, 3'd2, 3'd0, 8'h00);
    chk("ld44_ac", ac_out, 8'h44);
    chk("ld44_z", z, 0);
    cmd(3'b011, 3'd2, 3'd0, 8'h00);
    chk("clr_bus", bus_out, 8'h44);
    cmd(3'b100, 3'd2, 3'd0, 8'h00);
    chk("clr_ac", ac_out, 8'h00);
    chk("clr_z", z, 1);

    // Logic functions and AC+1
    cmd(3'b100, 3'd3, 3'd0, 8'h00);
    cmd(3'b101, 3'd0, 3'b011, 8'h00);
    chk("and_ac", ac_out, 8'h5A);
    cmd(3'b101, 3'd3, 3'b101, 8'h00);
    chk("xor_ac", ac_out, 8'h00);
    chk("xor_z", z, 1);
    cmd(3'b101, 3'd3, 3'b100, 8'h00);
    chk("or_ac", ac_out, 8'h5A);
    chk("or_z", z, 0);
    cmd(3'b101, 3'd0, 3'b111, 8'h00);
    chk("acinc_ac", ac_out, 8'h5B);
    chk("acinc_c", c, 0);
    cmd(3'b101, 3'd0, 3'b000, 8'h00);
    chk("pass_ac", ac_out, 8'hFF);
    cmd(3'b101, 3'd0, 3'b111, 8'h00);
    chk("acinc_wrap_ac", ac_out, 8'h00);
    chk("acinc_wrap_c", c, 1);
    chk("acinc_wrap_z", z, 1);

    // MUL: 0x10 * 0x20 = 0x200
    cmd(3'b001, 3'd4, 3'd0, 8'h10);
    cmd(3'b001, 3'd1, 3'd0, 8'h20);
    cmd(3'b100, 3'd4, 3'd0, 8'h00);
    cmd(3'b101, 3'd1, 3'b110, 8'h00);
`ifdef DATAPATH_UNIT_MUL_EN
    chk("mul_ac", ac_out, 8'h00);
    chk("mul_z", z, 1);
    chk("mul_c", c, 1);
`else
    chk("mul_ac", ac_out, 8'h20);
    chk("mul_z", z, 0);
    chk("mul_c", c, 0);
`endif

    // STA r5 <= 5A, then read back
    cmd(3'b100, 3'd3, 3'd0, 8'h00);
    cmd(3'b110, 3'd5, 3'd0, 8'h00);
    chk("sta_bus", bus_out, 8'h00);
    cmd(3'b100, 3'd0, 3'd0, 8'h00);
    cmd(3'b100, 3'd5, 3'd0, 8'h00);
    chk("sta_rd_ac", ac_out, 8'h5A);

    // NOP and reserved opcode change nothing but bus_out
    cmd(3'b000, 3'd5, 3'b001, 8'h77);
    chk("nop_bus", bus_out, 8'h00);
    chk("nop_ac", ac_out, 8'h5A);
    cmd(3'b100, 3'd7, 3'd0, 8'h00);
    cmd(3'b111, 3'd3, 3'b001, 8'h77);
    chk("rsv_bus", bus_out, 8'h00);
    chk("rsv_ac", ac_out, 8'h00);
    chk("rsv_z", z, 1);
    cmd(3'b100, 3'd3, 3'd0, 8'h00);
    chk("rsv_r3", ac_out, 8'h5A);

    // Continuous ctrl_valid: one acceptance every third cycle
    ctrl_valid = 1'b1; opr = 3'b001; rsel = 3'd6; alu_op = 3'd0; ext_data = 8'h11;
    tick(); chk("cont_rdy1", ctrl_ready, 0); chk("cont_done1", done, 0);
    tick(); chk("cont_rdy2", ctrl_ready, 0); chk("cont_done2", done, 1);
    tick(); chk("cont_rdy3", ctrl_ready, 1); chk("cont_done3", done, 0);
    tick(); chk("cont_rdy4", ctrl_ready, 0); chk("cont_done4", done, 0);
    tick(); chk("cont_rdy5", ctrl_ready, 0); chk("cont_done5", done, 1);
    tick(); chk("cont_rdy6", ctrl_ready, 1); chk("cont_done6", done, 0);
    ctrl_valid = 1'b0;
    cmd(3'b100, 3'd6, 3'd0, 8'h00);
    chk("cont_r6", ac_out, 8'h11);

    // Reset while in EXEC discards the WTR and suppresses done
    ctrl_valid = 1'b1; opr = 3'b001; rsel = 3'd0; ext_data = 8'h33;
    tick();
    ctrl_valid = 1'b0;
    rst = 1'b1;
    chk("rexec_state", ctrl_ready, 0);
    tick();
    rst = 1'b0;
    chk("rexec_done", done, 0);
    chk("rexec_ready", ctrl_ready, 1);
    chk("rexec_ac", ac_out, 8'h00);
    tick();
    chk("rexec_done2", done, 0);
    cmd(3'b100, 3'd0, 3'd0, 8'h00);
    chk("rexec_r0", ac_out, 8'h00);
    chk("rexec_z", z, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
